// File: rtl/meally_main_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : meally_main_fsm                                                |
// | Brief    : Two-direction traffic phase FSM with A-priority override.      |
// |            Optional MEALLY_MAIN_DBG_STATE_EN adds the dbg_state port.     |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module meally_main_fsm (
  input  logic       A,
  input  logic       B,
  input  logic       CLK,
  input  logic       finished,
  output logic       AL,
  output logic       BL,
  output logic       D,
`ifdef MEALLY_MAIN_DBG_STATE_EN
  input  logic       RST,
  output logic [1:0] dbg_state
`else
  input  logic       RST
`endif
);

  localparam logic [1:0] S0 = 2'b00;
  localparam logic [1:0] S1 = 2'b01;
  localparam logic [1:0] S2 = 2'b10;
  localparam logic [1:0] S3 = 2'b11;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       adv;

  // The timer only advances the cycle when no override request is pending.
  assign adv = finished & ~A & ~B;

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q <= S0;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S0: begin
        if (adv)         state_d = S1;
        else if (B & ~A) state_d = S2;
      end
      S1: begin
        if (adv)         state_d = S2;
        else if (A)      state_d = S0;
      end
      S2: begin
        if (adv)         state_d = S3;
        else if (A)      state_d = S0;
      end
      S3: begin
        if (adv | A)     state_d = S0;
        else if (B)      state_d = S2;
      end
      default:           state_d = S0;
    endcase
  end

  // Outputs depend on the state register only, so inputs reach them one edge later.
  always_comb begin
    AL = 1'b0;
    BL = 1'b0;
    D  = 1'b0;
    case (state_q)
      S0:      begin AL = 1'b1; D = 1'b1; end
      S1:      D  = 1'b1;
      S2:      BL = 1'b1;
      default: ;
    endcase
  end

`ifdef MEALLY_MAIN_DBG_STATE_EN
  assign dbg_state = state_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_meally_main_fsm.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_meally_main_fsm                                             |
// | Brief    : Directed self-checking bench for meally_main_fsm.              |
// | Revision : 1.0  initial release                                           |
// +--------------------------------------------------------------------------+
module tb_meally_main_fsm;

  logic A, B, CLK, finished, RST;
  logic AL, BL, D;
  int   total = 0;
  int   bad   = 0;
  logic [1:0] exp_state;

`ifdef MEALLY_MAIN_DBG_STATE_EN
  logic [1:0] dbg_state;
  meally_main_fsm dut (
    .A(A), .B(B), .CLK(CLK), .finished(finished),
    .AL(AL), .BL(BL), .D(D), .RST(RST), .dbg_state(dbg_state)
  );
`else
  meally_main_fsm dut (
    .A(A), .B(B), .CLK(CLK), .finished(finished),
    .AL(AL), .BL(BL), .D(D), .RST(RST)
  );
`endif

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic chk(input string tag, input logic [2:0] exp);
    logic [3:0] l;
    total++;
    assert ({AL, BL, D} === exp) else begin
      bad++;
      $error("FAIL %s observed=%b expected=%b", tag, {AL, BL, D}, exp);
    end
    l = {AL & ~BL, ~AL & ~BL & D, ~AL & BL, ~AL & ~BL & ~D};
    total++;
    assert ($countones(l) == 1) else begin
      bad++;
      $error("FAIL %s_onehot observed=%b expected=one-hot", tag, l);
    end
`ifdef MEALLY_MAIN_DBG_STATE_EN
    case (exp)
      3'b101:  exp_state = 2'b00;
      3'b001:  exp_state = 2'b01;
      3'b010:  exp_state = 2'b10;
      default: exp_state = 2'b11;
    endcase
    total++;
    assert (dbg_state === exp_state) else begin
      bad++;
      $error("FAIL %s_dbg observed=%b expected=%b", tag, dbg_state, exp_state);
    end
`endif
  endtask

  task automatic step(input string tag, input logic [2:0] exp);
    @(posedge CLK);
    #1;
    chk(tag, exp);
  endtask

  initial begin
    A = 1'b0; B = 1'b0; finished = 1'b0; RST = 1'b0;
    #2;
    chk("reset_async", 3'b101);
    @(negedge CLK);
    @(negedge CLK);
    RST = 1'b1;
    for (int i = 0; i < 10; i++) step("idle", 3'b101);

    // Full cycle driven by single-clock finished pulses
    finished = 1'b1; step("cyc_s1", 3'b001);
    finished = 1'b0; step("cyc_s1_hold", 3'b001);
    finished = 1'b1; step("cyc_s2", 3'b010);
    finished = 1'b1; step("cyc_s3", 3'b000);
    finished = 1'b1; step("cyc_s0", 3'b101);
    finished = 1'b0;

    // B request, including no combinational input-to-output path
    B = 1'b1;
    #1;
    chk("no_comb_path", 3'b101);
    step("b_to_s2", 3'b010);
    for (int i = 0; i < 5; i++) step("b_hold_s2", 3'b010);
    B = 1'b0; finished = 1'b1; step("s2_to_s3", 3'b000);
    finished = 1'b0; B = 1'b1; step("s3_b_to_s2", 3'b010);
    B = 1'b0;

    // A override from S2, S1, S3, and A=B=1 in S0
    A = 1'b1; step("a_s2_to_s0", 3'b101);
    A = 1'b0; finished = 1'b1; step("to_s1", 3'b001);
    finished = 1'b0; A = 1'b1; step("a_s1_to_s0", 3'b101);
    A = 1'b0; finished = 1'b1; step("to_s1b", 3'b001);
    step("to_s2b", 3'b010);
    step("to_s3b", 3'b000);
    finished = 1'b0; A = 1'b1; step("a_s3_to_s0", 3'b101);
    B = 1'b1; step("ab_s0_hold", 3'b101);
    step("ab_s0_hold2", 3'b101);

    // Masking of finished under A or B
    B = 1'b0; finished = 1'b1; step("mask_a_s0", 3'b101);
    A = 1'b0; B = 1'b1; step("mask_b_s0_to_s2", 3'b010);
    step("mask_b_s2", 3'b010);
    B = 1'b0; A = 1'b1; finished = 1'b0; step("back_s0", 3'b101);
    A = 1'b0; finished = 1'b1; step("to_s1c", 3'b001);
    B = 1'b1; step("mask_b_s1_hold", 3'b001);
    B = 1'b0; A = 1'b1; step("mask_a_s1_to_s0", 3'b101);
    A = 1'b0; finished = 1'b0;

    // Asynchronous reset in the middle of S2
    B = 1'b1; step("pre_rst_s2", 3'b010);
    B = 1'b0;
    @(negedge CLK);
    #2;
    RST = 1'b0;
    #1;
    chk("rst_mid_s2", 3'b101);
    @(negedge CLK);
    RST = 1'b1;
    step("post_rst_idle", 3'b101);
    finished = 1'b1; step("post_rst_first", 3'b001);
    finished = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/meally_main_fsm.md
MEALLY_MAIN_FSM -- requirements
Module: meally_main

Interface
- REQ-001: The module SHALL have no parameters; the state encoding and output patterns are fixed.
- REQ-002: CLK  input  1  the single system clock; all state updates occur on its rising edge.
- REQ-003: RST  input  1  reset, asynchronous and active-low; RST=0 forces the reset state immediately.
- REQ-004: A  input  1  direction-A override request (priority input); level-sensitive, sampled at the rising edge of CLK.
- REQ-005: B  input  1  direction-B override request; level-sensitive, sampled at the rising edge of CLK.
- REQ-006: finished  input  1  phase-timer expiry from an external timer, sampled at the rising edge of CLK.
- REQ-007: AL  output  1  light code bit 1; asserted only in phase S0 (A green).
- REQ-008: BL  output  1  light code bit 0; asserted only in phase S2 (B green).
- REQ-009: D  output  1  amber-direction flag; 1 in S0/S1, 0 in S2/S3.
- REQ-010: Port order SHALL be A, B, CLK, finished, AL, BL, D, RST.

Function
- REQ-011: The block SHALL implement a 4-state FSM: S0=2'b00 (A green), S1=2'b01 (amber after A), S2=2'b10 (B green), S3=2'b11 (amber after B).
- REQ-012: Define adv = finished & ~A & ~B; all transitions SHALL be evaluated at the rising edge of CLK.
- REQ-013: In S0: if adv, go to S1; else if B & ~A, go to S2; otherwise stay in S0.
- REQ-014: In S1: if adv, go to S2; else if A, go to S0; otherwise stay in S1 (B alone holds S1).
- REQ-015: In S2: if adv, go to S3; else if A, go to S0; otherwise stay in S2.
- REQ-016: In S3: if adv or A, go to S0; else if B & ~A, go to S2; otherwise stay in S3.
- REQ-017: When A=B=1, A SHALL win: S1, S2 and S3 go to S0, and S0 holds.
- REQ-018: finished while A or B is high SHALL be ignored.
- REQ-019: Outputs {AL,BL,D} SHALL decode from the state register only: S0=101, S1=001, S2=010, S3=000.
- REQ-020: Outputs SHALL change one clock edge after the sampled inputs, with no combinational input-to-output path.
- REQ-021: The outputs SHALL never show AL=BL=1.
- REQ-022: Downstream decode is L0=AL&~BL, L1=~AL&~BL&D, L2=~AL&BL, L3=~AL&~BL&~D, and exactly one of these SHALL be high at any time.

Reset
- REQ-023: While RST=0, state SHALL be S0 and {AL,BL,D}=101, independent of CLK.
- REQ-024: Reset asserted in the middle of any phase SHALL abort it immediately to S0.
- REQ-025: After RST rises, the first transition SHALL occur at the first rising edge of CLK that satisfies a REQ-013 to REQ-016 condition.

Configuration
- REQ-026: Macro MEALLY_MAIN_DBG_STATE_EN: when defined, an extra output port dbg_state (2 bits, placed after RST) SHALL present the raw state register.
- REQ-027: When MEALLY_MAIN_DBG_STATE_EN is defined, dbg_state SHALL read 2'b00 in reset.
- REQ-028: When MEALLY_MAIN_DBG_STATE_EN is not defined, the port SHALL be absent and the behaviour SHALL be otherwise identical.

Verification
- REQ-029: Reset then idle: RST=0 -> {AL,BL,D}=101; RST=1 with A=B=finished=0 for 10 clocks -> stays 101.
- REQ-030: Full cycle: pulse finished for 1 clock four times with A=B=0 -> outputs step 101 -> 001 -> 010 -> 000 -> 101, each change on the edge after the pulse.
- REQ-031: B request: in S0 hold B=1 (A=0) -> next edge 010; hold B in S2 for 5 clocks -> stays 010; from S3 raise B -> 010.
- REQ-032: A override: in S1, S2 and S3, raise A=1 -> next edge 101; A=B=1 in S0 -> stays 101.
- REQ-033: Masking: finished=1 with A=1 or B=1 -> no advance along the cycle (only the override transitions apply).
- REQ-034: Async reset: assert RST mid-clock while in S2 -> outputs 101 immediately, before the next CLK edge.
